// File: rtl/tmr_pkg.sv
// Shared definitions for the up/down timer counter: TCR bit map, prescale select and FSM states.
// The counter width defaults to 8 unless DATA_WIDTH is defined by the build.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package tmr_pkg;

   localparam int TMR_DW    = `DATA_WIDTH;
   localparam int TMR_DIV_W = 4;

   localparam int TCR_LOAD   = 7;
   localparam int TCR_UD     = 5;
   localparam int TCR_EN     = 4;
   localparam int TCR_CKS_HI = 1;
   localparam int TCR_CKS_LO = 0;

   typedef enum logic [1:0] {
      CKS_DIV2  = 2'b00,
      CKS_DIV4  = 2'b01,
      CKS_DIV8  = 2'b10,
      CKS_DIV16 = 2'b11
   } cks_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } cnt_state_e;

endpackage

// File: rtl/tmr_prescaler.sv
// Free-running prescale divider; tick marks the last pclk of each 2**(cks+1) period.
// clear beats freeze, so a load during a debug halt still restarts the period.
module tmr_prescaler
   import tmr_pkg::*;
#(
   parameter int DIV_W = TMR_DIV_W
) (
   input  logic pclk,
   input  logic preset,
   input  logic clear,
   input  logic freeze,
   input  cks_e cks,
   output logic tick
);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] mask;

   always_ff @(posedge pclk) begin
      if (preset)
         div_cnt <= '0;
      else if (clear)
         div_cnt <= '0;
      else if (!freeze)
         div_cnt <= div_cnt + 1'b1;
   end

   // No clear on cks change: the new divide applies at the next matching count.
   always_comb begin
      mask = '0;
      for (int i = 0; i < DIV_W; i++)
         mask[i] = (i <= int'(cks));
   end

   assign tick = ((div_cnt & mask) == mask);

endmodule

// File: rtl/tmr_counter.sv
// Up/down timer counter with clock-select prescaler, feeding the overflow/underflow comparator.
// Define TMR_CNT_DBG_HALT_EN to add the dbg_halt port that freezes counting for a debugger.
module tmr_counter
   import tmr_pkg::*;
#(
   parameter int DW    = TMR_DW,
   parameter int DIV_W = TMR_DIV_W
) (
   input  logic          pclk,
   input  logic          preset,
   input  logic [DW-1:0] TDR,
   input  logic [DW-1:0] TCR,
`ifdef TMR_CNT_DBG_HALT_EN
   input  logic          dbg_halt,
`endif
   output logic [DW-1:0] TCNT,
   output logic          count_enable,
   output logic          count_up_down
);

   cnt_state_e state;
   logic       load_d;
   logic       load_pulse;
   logic       halt;
   logic       tick;
   logic       en;
   logic       presc_clear;
   logic       unused_tcr;

`ifdef TMR_CNT_DBG_HALT_EN
   assign halt = dbg_halt;
`else
   assign halt = 1'b0;
`endif

   assign en         = TCR[TCR_EN];
   assign load_pulse = TCR[TCR_LOAD] & ~load_d;
   assign unused_tcr = ^{TCR[6], TCR[3:2]};

   // Keep div_cnt at 0 throughout IDLE, including the edge that leaves RUN.
   assign presc_clear = load_pulse | (state == ST_IDLE) |
                        ((state == ST_RUN) & ~en & ~halt);

   tmr_prescaler #(.DIV_W(DIV_W)) u_presc (
      .pclk   (pclk),
      .preset (preset),
      .clear  (presc_clear),
      .freeze (halt),
      .cks    (cks_e'(TCR[TCR_CKS_HI:TCR_CKS_LO])),
      .tick   (tick)
   );

   always_ff @(posedge pclk) begin
      if (preset) begin
         state         <= ST_IDLE;
         load_d        <= 1'b0;
         TCNT          <= '0;
         count_enable  <= 1'b0;
         count_up_down <= 1'b0;
      end else begin
         load_d        <= TCR[TCR_LOAD];
         count_up_down <= TCR[TCR_UD];

         if (!halt) begin
            case (state)
               ST_IDLE: if (en)  state <= ST_RUN;
               ST_RUN:  if (!en) state <= ST_IDLE;
               default:          state <= ST_IDLE;
            endcase
         end

         if (load_pulse) begin
            TCNT         <= TDR;
            count_enable <= 1'b0;
         end else if (halt) begin
            count_enable <= 1'b0;
         end else if ((state == ST_RUN) && tick) begin
            TCNT         <= TCR[TCR_UD] ? TCNT - 1'b1 : TCNT + 1'b1;
            count_enable <= 1'b1;
         end else begin
            count_enable <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tmr_counter.sv
// Directed bench for tmr_counter: reset, up/down counting, wrap, load/tick collision and debug halt.
// Build with TMR_CNT_DBG_HALT_EN defined to also exercise dbg_halt.
module tb_tmr_counter;

   logic       pclk = 1'b0;
   logic       preset;
   logic [7:0] TDR;
   logic [7:0] TCR;
   logic [7:0] TCNT;
   logic       count_enable;
   logic       count_up_down;
`ifdef TMR_CNT_DBG_HALT_EN
   logic       dbg_halt;
`endif

   int n_tot = 0;
   int n_bad = 0;

   always #5 pclk = ~pclk;

   tmr_counter dut (
      .pclk          (pclk),
      .preset        (preset),
      .TDR           (TDR),
      .TCR           (TCR),
`ifdef TMR_CNT_DBG_HALT_EN
      .dbg_halt      (dbg_halt),
`endif
      .TCNT          (TCNT),
      .count_enable  (count_enable),
      .count_up_down (count_up_down)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One active edge, then settle so outputs are sampled and inputs driven away from it.
   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Packs {TCNT, count_enable} for compact checks.
   function automatic logic [31:0] obs();
      return {23'd0, TCNT, count_enable};
   endfunction

   function automatic logic [31:0] exp_v(input logic [7:0] cnt, input logic ce);
      return {23'd0, cnt, ce};
   endfunction

   initial begin
`ifdef TMR_CNT_DBG_HALT_EN
      dbg_halt = 1'b0;
`endif
      // 1: reset dominates random controls
      preset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         TCR = 8'($urandom);
         TDR = 8'($urandom);
         step();
         chk("rst_cnt", obs(), exp_v(8'h00, 1'b0));
         chk("rst_ud", {31'd0, count_up_down}, 32'd0);
      end
      preset = 1'b0;
      TCR    = 8'h00;
      TDR    = 8'h00;
      step();
      chk("idle_hold", obs(), exp_v(8'h00, 1'b0));

      // 2: up count, /2
      TCR = 8'h10;
      step();
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("up_gap", obs(), exp_v(8'(i - 1), 1'b0));
         step();
         chk("up_step", obs(), exp_v(8'(i), 1'b1));
      end
      TCR = 8'h00;
      step();
      chk("stop", obs(), exp_v(8'h04, 1'b0));
      step();
      chk("stop_hold", obs(), exp_v(8'h04, 1'b0));

      // 3: load FE, count up through the FF->00 wrap
      TDR = 8'hFE;
      TCR = 8'h80;
      step();
      chk("load_fe", obs(), exp_v(8'hFE, 1'b0));
      TCR = 8'h10;
      step();
      step();
      chk("fe_wait", obs(), exp_v(8'hFE, 1'b0));
      step();
      chk("to_ff", obs(), exp_v(8'hFF, 1'b1));
      step();
      step();
      chk("wrap_00", obs(), exp_v(8'h00, 1'b1));
      step();
      step();
      chk("to_01", obs(), exp_v(8'h01, 1'b1));
      TCR = 8'h00;
      step();
      step();
      chk("stop2", obs(), exp_v(8'h01, 1'b0));

      // 4: load 01, count down at /16 through 00->FF
      TDR = 8'h01;
      TCR = 8'h80;
      step();
      chk("load_01", obs(), exp_v(8'h01, 1'b0));
      TCR = 8'h33;
      step();
      chk("dn_dir", {31'd0, count_up_down}, 32'd1);
      repeat (15) step();
      chk("dn_wait", obs(), exp_v(8'h01, 1'b0));
      step();
      chk("dn_00", obs(), exp_v(8'h00, 1'b1));
      repeat (15) step();
      chk("dn_wait2", obs(), exp_v(8'h00, 1'b0));
      step();
      chk("dn_ff", obs(), exp_v(8'hFF, 1'b1));
      chk("dn_dir2", {31'd0, count_up_down}, 32'd1);
      TCR = 8'h00;
      step();
      chk("dir_back", {31'd0, count_up_down}, 32'd0);

      // 5: load coincident with a tick wins, next step a full period later
      TDR = 8'h55;
      TCR = 8'h10;
      step();
      step();
      TCR = 8'h90;
      step();
      chk("ld_tick", obs(), exp_v(8'h55, 1'b0));
      TCR = 8'h10;
      step();
      chk("ld_gap", obs(), exp_v(8'h55, 1'b0));
      step();
      chk("ld_next", obs(), exp_v(8'h56, 1'b1));

`ifdef TMR_CNT_DBG_HALT_EN
      // 6: halt just before a tick, release resumes with that same tick
      step();
      chk("pre_halt", obs(), exp_v(8'h56, 1'b0));
      dbg_halt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("halted", obs(), exp_v(8'h56, 1'b0));
      end
      dbg_halt = 1'b0;
      step();
      chk("resume", obs(), exp_v(8'h57, 1'b1));
      step();
      chk("resume_gap", obs(), exp_v(8'h57, 1'b0));
`endif

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
